// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel stage: two line buffers plus a
// three-column shift register, emitting one window per interior pixel.
module sobel_window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       pix_valid_i,
    input  logic [PIX_W-1:0]           pix_i,
    output logic                       win_valid_o,
    output logic [9*PIX_W-1:0]         win_o,
    output logic [$clog2(IMG_H)-1:0]   row_o,
    output logic [$clog2(IMG_W)-1:0]   col_o,
    output logic                       frame_done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [PIX_W-1:0]   lb0 [IMG_W];
    logic [PIX_W-1:0]   lb1 [IMG_W];

    // Window columns: *_l is column c-2, *_m is column c-1 relative to the next pixel.
    logic [PIX_W-1:0]   top_l, top_m, mid_l, mid_m, bot_l, bot_m;

    logic               accept;
    logic               emit;
    logic               last_pix;
    logic [PIX_W-1:0]   new_top;
    logic [PIX_W-1:0]   new_mid;
    logic [9*PIX_W-1:0] win_next;

    always_comb begin
        accept   = pix_valid_i & ~rst_i;
        new_top  = lb1[col];
        new_mid  = lb0[col];
        emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
        last_pix = (row == ROW_LAST) && (col == COL_LAST);
        win_next = {pix_i,   bot_m, bot_l,
                    new_mid, mid_m, mid_l,
                    new_top, top_m, top_l};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers and window shifter are deliberately left unreset; the
    // row/col gating on emit keeps stale contents from ever reaching win_o.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_i;
            top_l    <= top_m;
            top_m    <= new_top;
            mid_l    <= mid_m;
            mid_m    <= new_mid;
            bot_l    <= bot_m;
            bot_m    <= pix_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            win_o        <= '0;
            row_o        <= '0;
            col_o        <= '0;
        end else begin
            win_valid_o  <= emit;
            frame_done_o <= accept && last_pix;
            if (emit) begin
                win_o <= win_next;
                row_o <= row - RW'(1);
                col_o <= col - CW'(1);
            end
        end
    end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel gradient/threshold stage. It accepts one grayscale pixel per valid cycle in raster order (row-major, top-left first), buffers the two previous image rows internally, and emits a complete 3x3 window, plus the coordinates of its centre pixel, for every interior pixel of the frame. Image dimensions come from the Sobel configuration package (IMAGE_COLUMN_SIZE, IMAGE_ROW_SIZE).

## Interface
- IMG_W, default IMAGE_COLUMN_SIZE (256), pixels per row; legal range >= 3
- IMG_H, default IMAGE_ROW_SIZE (256), rows per frame; legal range >= 3
- PIX_W, default 8, bits per pixel
- clk_i  in  1  single clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- pix_valid_i  in  1  pixel on pix_i is accepted this cycle; no backpressure, so the block always accepts
- pix_i  in  PIX_W  input pixel, raster order
- win_valid_o  out  1  win_o, row_o and col_o hold a new window this cycle (one-cycle pulse per window)
- win_o  out  9*PIX_W  3x3 window; slice [PIX_W*(3*i+j) +: PIX_W] = pixel at (row_o-1+i, col_o-1+j), i,j in 0..2 (i=0 top row, j=0 left column)
- row_o  out  $clog2(IMG_H)  centre row of window
- col_o  out  $clog2(IMG_W)  centre column of window
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) track the position of the next accepted pixel. They advance only on pix_valid_i. col wraps to 0 and increments row at IMG_W-1. Both wrap to 0 after (IMG_H-1, IMG_W-1).
- Two line buffers of IMG_W x PIX_W. lb0 holds row r-1 and lb1 holds row r-2. On acceptance at column c: the new column {lb1[c], lb0[c], pix_i} is shifted into the 3-column window register, then lb1[c] <= lb0[c] and lb0[c] <= pix_i. Reads happen in the same cycle as the write, and return the old contents.
- Window emission: a pixel accepted at (r,c) with r >= 2 and c >= 2 completes the window centred at (r-1, c-1). It produces win_valid_o=1, row_o=r-1, col_o=c-1.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never window centres. Per frame, exactly (IMG_H-2)*(IMG_W-2) windows are emitted; with the default sizes this is 64516.
- Window-register contents at c=0 and c=1 mix in the previous row. They are never emitted, and no explicit flush is needed.
- Back-to-back frames: the first pixel of frame N+1 may arrive the cycle after the last pixel of frame N. Stale line-buffer data is never emitted, because row < 2 at the start of the new frame.

## Timing
- Latency: window outputs are registered and appear in the cycle after the completing pixel is accepted.
- Behaviour when pix_valid_i=0:
  - win_valid_o=0 and frame_done_o=0 next cycle.
  - win_o, row_o and col_o hold their last values.
  - Counters and buffers do not change.
- frame_done_o is asserted in the cycle after acceptance of pixel (IMG_H-1, IMG_W-1). That is the same cycle as the final window pulse (centre IMG_H-2, IMG_W-2).
- Reset values: win_valid_o=0, frame_done_o=0, win_o=0, row_o=0, col_o=0, col=0, row=0.
  - Line-buffer contents are not cleared.
- Reset mid-frame:
  - The next accepted pixel is treated as (0,0).
  - No window is emitted until two full rows plus three pixels have been accepted.
  - rst_i has priority over pix_valid_i in the same cycle; that pixel is dropped.
- Throughput: one pixel per clock sustained. There are no bubbles at row or frame boundaries.

## Test plan
- Full frame, IMG_W=IMG_H=256, pix = (r+c) mod 256, continuous valid:
  - 64516 win_valid_o pulses.
  - First window has centre (1,1) and win_o bytes (top-left to bottom-right) 0,1,2,1,2,3,2,3,4.
  - Last window has centre (254,254).
  - frame_done_o pulses once, coincident with the last window.
- Small frame, IMG_W=5, IMG_H=4, pix = 10*r+c:
  - Exactly 6 windows, centres (1,1)..(2,3) in raster order.
  - Window at (2,3) = 12,13,14,22,23,24,32,33,34.
  - No window is emitted while col < 2.
- Random pix_valid_i gaps (~40% idle), same small frame:
  - Window values and order are identical to the gap-free run.
  - win_valid_o never asserts in the cycle after an idle cycle.
  - Outputs hold across gaps.
- Two back-to-back frames, IMG_W=5, IMG_H=4, with frame 2 pixels = frame 1 + 100:
  - frame 2 windows contain only frame 2 values.
  - frame_done_o pulses twice, exactly 20 accepted pixels apart.
- rst_i asserted after 13 pixels of a 5x4 frame, then a fresh frame:
  - All outputs read 0 the cycle after reset.
  - The fresh frame yields the exact 6 windows of the small-frame test.
  - The pixel presented during rst_i is ignored.
- rst_i and pix_valid_i asserted in the same cycle:
  - The next accepted pixel is at position (0,0).
  - The first window appears only after 13 further pixels (5x4 frame).
